multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter: NUM_SLICES, default 4, number of 16-bit slices; operand width W = 16*NUM_SLICES; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  requester presents an operation.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: op_sub  input  1  0 = A+B, 1 = A-B; sampled on acceptance.
REQ-007 Port: op_a  input  W  operand A; sampled on acceptance.
REQ-008 Port: op_b  input  W  operand B; sampled on acceptance.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: result  output  W  sum or difference, modulo 2^W.
REQ-012 Port: carry_out  output  1  carry from the MSB slice; for subtraction, 1 = no borrow.
REQ-013 Port: overflow  output  1  two's-complement signed overflow of the W-bit operation.
REQ-014 Port: busy  output  1  high in RUN or DONE.

Function
REQ-015 The block SHALL contain exactly one instance of the existing 16-bit ripple-carry adder and compute the W-bit operation by time-multiplexing it, one slice per cycle, LSB slice first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 in_ready SHALL equal 1 only in IDLE.
REQ-018 Acceptance (IDLE, in_valid=1) SHALL register op_a, op_b and op_sub, clear the slice index to 0, and move to RUN.
REQ-019 Acceptance SHALL preset the carry register to op_sub.
REQ-020 Per RUN cycle: adder a = A[idx], adder b = B[idx] XOR {16{sub}}, adder cin = carry register.
REQ-021 Per RUN cycle: the sum is written to result slice idx, cout is written to the carry register, and idx increments.
REQ-022 After the cycle with idx = NUM_SLICES-1 the FSM SHALL enter DONE.
REQ-023 On entering DONE: carry_out = final carry; overflow = (a_msb == b'_msb) AND (sum_msb != a_msb), where b' is the inverted B when subtracting.
REQ-024 Latency: out_valid SHALL rise exactly NUM_SLICES cycles after the acceptance edge (4 for the default).
REQ-025 In DONE, out_valid=1 and result, carry_out and overflow SHALL stay stable until out_ready=1.
REQ-026 The DONE cycle with out_ready=1 SHALL return the FSM to IDLE and drop out_valid next cycle; no new acceptance occurs in that same cycle.
REQ-027 Minimum issue interval SHALL be NUM_SLICES+2 cycles with out_ready held high.
REQ-028 in_valid in RUN or DONE SHALL be ignored; changes to op_* in RUN or DONE SHALL NOT affect the computation in flight.
REQ-029 result SHALL be undefined-free: slices not yet written in RUN hold their previous values, and out_valid masks them.
REQ-030 Wrap-around: sums at or above 2^W SHALL wrap modulo 2^W with carry_out=1.
REQ-031 The slice index SHALL never exceed NUM_SLICES-1.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, busy=0.
REQ-033 rst_n=0 SHALL also immediately clear result, carry_out, overflow, the carry register and the slice index to 0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation; no out_valid is produced for it.
REQ-035 After rst_n deasserts, the first rising edge SHALL be able to accept an operation.

Verification (NUM_SLICES=4, W=64)
REQ-036 Add with ripple through all slices: A=0x0000_0000_0000_FFFF, B=0x1 -> result 0x0000_0000_0001_0000, carry_out=0, overflow=0, out_valid 4 cycles after acceptance.
REQ-037 Full-width wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, add -> result 0, carry_out=1, overflow=0.
REQ-038 Subtraction: A=0x5, B=0x7, sub -> result 0xFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow).
REQ-039 Signed overflow: A=0x8000_0000_0000_0000, B=0x1, sub -> result 0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry_out=1.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> result stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE, then the next acceptance.
REQ-041 Reset at RUN idx=2 -> outputs cleared at once, no out_valid; the next operation 3+4 returns 7 with 4-cycle latency.

Source files
------------

// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Sequential W-bit adder/subtractor (W = 16*NUM_SLICES).  A single 16-bit
// ripple-carry adder is reused once per cycle, LSB slice first, with the
// carry held in a register between slices.  Subtraction is A + ~B + 1: the
// B slices are inverted and the carry register is preset to 1.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : requester presents an operation
//   in_ready   : high only in IDLE; acceptance = in_valid & in_ready
//   op_sub     : 0 = A+B, 1 = A-B (sampled on acceptance)
//   op_a/op_b  : W-bit operands (sampled on acceptance)
//   out_valid  : result available (DONE state)
//   out_ready  : consumer takes the result
//   result     : W-bit sum/difference modulo 2^W
//   carry_out  : carry from the MSB slice (subtract: 1 = no borrow)
//   overflow   : two's-complement signed overflow
//   busy       : high in RUN or DONE
// ---------------------------------------------------------------------------

// 16-bit ripple-carry adder, one full adder per bit.
module rca16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[16];
endmodule

module multiword_add_seq #(
  parameter int NUM_SLICES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op_sub,
  input  logic [16*NUM_SLICES-1:0]   op_a,
  input  logic [16*NUM_SLICES-1:0]   op_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*NUM_SLICES-1:0]   result,
  output logic                       carry_out,
  output logic                       overflow,
  output logic                       busy
);
  localparam int W  = 16 * NUM_SLICES;
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx_reg;
  logic [W-1:0]    result_reg;
  logic            carry_out_reg;
  logic            overflow_reg;
  logic            out_valid_reg;

  // Operand registers viewed as arrays of 16-bit slices.
  logic [15:0] a_slice [NUM_SLICES];
  logic [15:0] b_slice [NUM_SLICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[16*gi +: 16];
      assign b_slice[gi] = b_reg[16*gi +: 16];
    end
  endgenerate

  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic [15:0] adder_sum;
  logic        adder_cout;

  assign adder_a = a_slice[idx_reg];
  assign adder_b = b_slice[idx_reg] ^ {16{sub_reg}};

  rca16 u_rca16 (
    .a    (adder_a),
    .b    (adder_b),
    .cin  (carry_reg),
    .sum  (adder_sum),
    .cout (adder_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            sub_reg   <= op_sub;
            carry_reg <= op_sub;   // the "+1" of A + ~B + 1
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result_reg[16*idx_reg +: 16] <= adder_sum;
          carry_reg                    <= adder_cout;
          if (idx_reg == LAST_IDX) begin
            // idx stays at the last slice; it is cleared on the next acceptance.
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            carry_out_reg <= adder_cout;
            overflow_reg  <= (adder_a[15] == adder_b[15]) &&
                             (adder_sum[15] != adder_a[15]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE takes this whole cycle, so no acceptance here.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
//
// Directed and random operations on the default 4-slice (64-bit) build.
// Expected values come from 65-bit integer arithmetic and the signed
// overflow rule, independent of the slice-by-slice hardware.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;
  localparam int N = 4;
  localparam int W = 16 * N;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [W-1:0] got_result;
  logic         got_carry;
  logic         got_ovf;

  multiword_add_seq #(.NUM_SLICES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] t;
    if (!s) t = {1'b0, a} + {1'b0, b};
    else    t = {1'b0, a} + {1'b0, ~b} + 1;
    r = t[W-1:0];
    c = t[W];
    if (!s) v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    else    v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  // One full operation: accept, measure latency, check, optional
  // backpressure for 'hold' cycles, then hand the result off.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold, input bit iv_in_done);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    int           lat;
    model(a, b, s, er, ec, ev);
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    // Scramble inputs in flight; they must not matter.
    in_valid = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    op_sub = ~s;
    chk("busy_run", 64'(busy), 64'd1);
    chk("in_ready_run", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(N));
    chk("result", result, er);
    chk("carry_out", 64'(carry_out), 64'(ec));
    chk("overflow", 64'(overflow), 64'(ev));
    got_result = result; got_carry = carry_out; got_ovf = overflow;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (iv_in_done) begin
        in_valid = 1'b1;
        op_a = 64'h1234_5678_9ABC_DEF0;
        op_b = 64'h0FED_CBA9_8765_4321;
        op_sub = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_result", result, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    $display("op a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d lat=%0d hold=%0d",
             a, b, s, got_result, got_carry, got_ovf, lat, hold);
  endtask

  initial begin
    int t1;
    bit saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // Ripple through all slices.
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0, 1'b0);
    chk("ripple_lit", got_result, 64'h0000_0000_0001_0000);
    chk("ripple_c", 64'(got_carry), 64'd0);
    t1 = acc_cyc;
    // Full-width wrap, issued back-to-back.
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
    chk("issue_interval", 64'(acc_cyc - t1), 64'(N + 2));
    chk("wrap_lit", got_result, 64'h0);
    chk("wrap_c", 64'(got_carry), 64'd1);
    // Subtraction with borrow.
    do_op(64'h5, 64'h7, 1'b1, 0, 1'b0);
    chk("sub_lit", got_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_c", 64'(got_carry), 64'd0);
    // Signed overflow on subtraction.
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0, 1'b0);
    chk("ovf_lit", got_result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf_v", 64'(got_ovf), 64'd1);
    chk("ovf_c", 64'(got_carry), 64'd1);
    // Backpressure with new operands pending, then that operation.
    do_op(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b0, 5, 1'b1);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0, 1'b0);

    // Reset in the middle of RUN (slice index 2).
    op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1111_1111_1111_1111;
    op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_c", 64'(carry_out), 64'd0);
    chk("midrst_v", 64'(overflow), 64'd0);
    saw_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    #2 rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    chk("midrst_no_valid", 64'(saw_valid), 64'd0);
    $display("reset mid-run: aborted operation, out_valid seen=%0d", saw_valid);
    do_op(64'd3, 64'd4, 1'b0, 0, 1'b0);
    chk("post_rst_lit", got_result, 64'd7);

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) ra = ~64'h0;
      do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
